apb_soc_ctrl_boot: RTL
======================

# apb_soc_ctrl_boot

Parametrised APB SoC control slave for multi-cluster systems. It replaces fixed per-core resource registers with NB_CLUSTERS×NB_CORES configurable-width registers and adds a sequenced cluster boot controller. The controller raises per-cluster fetch-enable one cluster at a time, with a programmable inter-cluster delay. It sits on the SoC APB bus beside the other peripherals and drives cluster fetch-enable and boot-address inputs.

## Interface
- APB_ADDR_WIDTH, 12, APB address width; decode uses PADDR[9:2].
- NB_CLUSTERS, 1, number of clusters (1..8).
- NB_CORES, 4, cores per cluster (1..16).
- RES_WIDTH, 8, width of each per-core resource register (1..32).
- DLY_WIDTH, 8, width of the inter-cluster delay counter.
- BOOT_ADDR_RST, 32'h1C00_0000, reset value of the boot address.
- Reset is HRESETn (asynchronous, active-low); clock is HCLK.
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  APB address.
- PWDATA  in  32  write data.
- PWRITE  in  1  write strobe.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data, combinational.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  error response, combinational.
- cluster_fetch_en_o  out  NB_CLUSTERS  per-cluster fetch enable, registered.
- boot_addr_o  out  32  boot address, registered.
- res_core_o  out  NB_CLUSTERS*NB_CORES*RES_WIDTH  flattened resource registers; core k occupies bits [k*RES_WIDTH +: RES_WIDTH].

## Operation
- An access is PSEL & PENABLE. Writes commit at the HCLK edge that ends the access cycle.
- Register map:
  - 0x010 INFO (RO): {NB_CORES[15:0], NB_CLUSTERS[15:0]}.
  - 0x020 BOOT_CMD (WO, reads 0): bit31 = clear; bits[NB_CLUSTERS-1:0] = start mask.
  - 0x024 BOOT_DLY (RW): DLY_WIDTH bits, reset 0.
  - 0x028 BOOT_ADDR (RW): 32 bits, reset BOOT_ADDR_RST.
  - 0x02C STATUS (RO): bit31 busy; bits[26:24] current index; bits[NB_CLUSTERS-1:0] = cluster_fetch_en_o.
  - 0x100+4k RES_CORE[k] (RW), k < NB_CLUSTERS*NB_CORES: RES_WIDTH bits, reset 0, upper read bits 0.
- PSLVERR=1 and the access has no effect on any of:
  - an unmapped address;
  - a write to INFO or STATUS;
  - a BOOT_CMD or BOOT_ADDR write while busy.
- Reads of unmapped addresses return 0.
- BOOT_CMD write while idle:
  - bit31=1: clear all fetch-enables; mask ignored.
  - Otherwise, a non-zero mask latches the mask and starts the sequence.
  - Mask bits ≥ NB_CLUSTERS are ignored. A zero effective mask does nothing and raises no error.
- FSM states IDLE, SCAN, WAIT; busy = (state != IDLE).
  - IDLE → SCAN with idx=0 on a start.
  - SCAN with mask[idx]=1: set fetch_en[idx], load cnt=BOOT_DLY, go to WAIT.
  - SCAN with mask[idx]=0: if idx==NB_CLUSTERS-1 go to IDLE, else idx+1.
  - WAIT with cnt≠0: cnt−1.
  - WAIT with cnt==0: if idx==NB_CLUSTERS-1 go to IDLE, else idx+1 and go to SCAN.
- Fetch-enables are sticky; only the clear command or reset drops them. A masked cluster that is already enabled stays 1, and the delay still applies.
- BOOT_DLY writes during busy are legal; the new value is used at the next counter load.

## Timing
- Reset: all outputs and registers at reset values; state IDLE, idx 0, cnt 0, fetch_en 0, boot_addr_o=BOOT_ADDR_RST, res_core_o 0, PRDATA 0 when not selected.
- Register writes in access cycle T are visible on outputs and PRDATA from T+1.
- Start write at T: busy from T+1; the first enabled cluster rises at T+2 if mask[0]=1.
- Consecutive set mask bits rise exactly BOOT_DLY+2 cycles apart. Each skipped cluster adds 1 cycle.
- busy falls on the cycle after the last index completes.
- Asynchronous reset mid-sequence aborts immediately; all fetch-enables drop without waiting for HCLK.

## Structure
- Package apb_soc_ctrl_boot_pkg holds the register offset localparams and the boot_state_e enum (IDLE/SCAN/WAIT).
- Sub-module cluster_boot_seq contains the FSM, idx and cnt. It takes start/clear/mask/dly and produces fetch_en/busy/idx.
- Top level contains the APB decode, the register file (generate loop over cores) and PRDATA/PSLVERR muxing.

## Test plan
- Reset, then read INFO with NB_CLUSTERS=4, NB_CORES=8 -> 0x0008_0004; boot_addr_o=0x1C00_0000; all fetch_en 0.
- Write RES_CORE[31]=0xFFFF_FFA5 with RES_WIDTH=8 -> read 0x0000_00A5, res_core_o[255:248]=0xA5; access at 0x180 (k=32) -> PSLVERR=1, read 0.
- BOOT_DLY=3, BOOT_CMD=0x5 at T -> fetch_en[0] rises at T+2, fetch_en[2] at T+8 (one skip), busy low at T+13; STATUS=0x0000_0005.
- BOOT_ADDR write and a second BOOT_CMD while busy -> PSLVERR=1, boot_addr_o and sequence unchanged.
- Idle BOOT_CMD=0x8000_0000 after boot -> fetch_en all 0 at T+1; BOOT_CMD=0 -> no busy, PSLVERR=0.
- HRESETn low while in WAIT -> fetch_en 0 asynchronously; after release, STATUS=0 and a new start behaves as from reset.

Source files
------------

// File: rtl/apb_soc_ctrl_boot_pkg.sv
// Shared definitions for the APB SoC control slave: register word offsets
// (PADDR[9:2]) and the cluster boot sequencer state encoding.
package apb_soc_ctrl_boot_pkg;

    // Word offsets, i.e. byte address >> 2
    localparam logic [7:0] REG_INFO      = 8'h04;  // 0x010
    localparam logic [7:0] REG_BOOT_CMD  = 8'h08;  // 0x020
    localparam logic [7:0] REG_BOOT_DLY  = 8'h09;  // 0x024
    localparam logic [7:0] REG_BOOT_ADDR = 8'h0A;  // 0x028
    localparam logic [7:0] REG_STATUS    = 8'h0B;  // 0x02C
    localparam logic [7:0] REG_RES_BASE  = 8'h40;  // 0x100

    // Cluster index width; supports up to 8 clusters
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } boot_state_e;

endpackage

// File: rtl/apb_soc_ctrl_boot_cluster_boot_seq.sv
// Cluster boot sequencer: walks the latched start mask one cluster at a time,
// raising each selected fetch-enable and then holding off for the programmed
// delay before moving on. Fetch-enables are sticky until a clear command.
module cluster_boot_seq
    import apb_soc_ctrl_boot_pkg::*;
#(
    parameter int NB_CLUSTERS = 1,
    parameter int DLY_WIDTH   = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [NB_CLUSTERS-1:0] mask_i,
    input  logic [DLY_WIDTH-1:0]   dly_i,
    output logic [NB_CLUSTERS-1:0] fetch_en_o,
    output logic                   busy_o,
    output logic [IDX_W-1:0]       idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_CLUSTERS - 1);

    boot_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
    // Mask and enables padded to 8 bits so idx can index them for any cluster count
    logic [7:0]           mask_q, mask_d;
    logic [7:0]           fe_q, fe_d;

    // Next-state logic: scan the mask, set enables, count down the delay
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        fe_d    = fe_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    fe_d = '0;
                end else if (start_i) begin
                    mask_d  = 8'(mask_i);
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (mask_q[idx_q]) begin
                    fe_d[idx_q] = 1'b1;
                    cnt_d       = dly_i;
                    state_d     = WAIT;
                end else if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_WIDTH'(1);
                end else if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = SCAN;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer state; asynchronous reset drops all enables immediately
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            fe_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            fe_q    <= fe_d;
        end
    end

    assign fetch_en_o = fe_q[NB_CLUSTERS-1:0];
    assign busy_o     = (state_q != IDLE);
    assign idx_o      = idx_q;

endmodule

// File: rtl/apb_soc_ctrl_boot.sv
// APB SoC control slave: per-core resource registers, boot address/delay
// registers and a sequenced cluster boot controller.
module apb_soc_ctrl_boot
    import apb_soc_ctrl_boot_pkg::*;
#(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          NB_CLUSTERS    = 1,
    parameter int          NB_CORES       = 4,
    parameter int          RES_WIDTH      = 8,
    parameter int          DLY_WIDTH      = 8,
    parameter logic [31:0] BOOT_ADDR_RST  = 32'h1C00_0000
) (
    input  logic                                    HCLK,
    input  logic                                    HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]               PADDR,
    input  logic [31:0]                             PWDATA,
    input  logic                                    PWRITE,
    input  logic                                    PSEL,
    input  logic                                    PENABLE,
    output logic [31:0]                             PRDATA,
    output logic                                    PREADY,
    output logic                                    PSLVERR,
    output logic [NB_CLUSTERS-1:0]                  cluster_fetch_en_o,
    output logic [31:0]                             boot_addr_o,
    output logic [NB_CLUSTERS*NB_CORES*RES_WIDTH-1:0] res_core_o
);

    localparam int NB_RES = NB_CLUSTERS * NB_CORES;

    logic [7:0]             addr_w;
    logic                   access, sel_info, sel_cmd, sel_dly, sel_addr, sel_status;
    logic                   res_hit, mapped, err, wr_en;
    logic                   busy, seq_start, seq_clear;
    logic [IDX_W-1:0]       idx;
    logic [NB_RES-1:0]      res_sel;
    logic [NB_RES*RES_WIDTH-1:0] res_flat;
    logic [DLY_WIDTH-1:0]   boot_dly_q, boot_dly_d;
    logic [31:0]            boot_addr_q, boot_addr_d;
    logic [31:0]            rdata;
    logic                   unused_addr;

    assign addr_w      = PADDR[9:2];
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:10], PADDR[1:0]};
    assign access      = PSEL & PENABLE;
    assign sel_info    = (addr_w == REG_INFO);
    assign sel_cmd     = (addr_w == REG_BOOT_CMD);
    assign sel_dly     = (addr_w == REG_BOOT_DLY);
    assign sel_addr    = (addr_w == REG_BOOT_ADDR);
    assign sel_status  = (addr_w == REG_STATUS);
    assign res_hit     = |res_sel;
    assign mapped      = sel_info | sel_cmd | sel_dly | sel_addr | sel_status | res_hit;

    // Rejected accesses: unmapped, writes to read-only, boot controls while busy
    assign err   = ~mapped
                 | (PWRITE & (sel_info | sel_status))
                 | (PWRITE & busy & (sel_cmd | sel_addr));
    assign wr_en = access & PWRITE & ~err;

    assign seq_clear = wr_en & sel_cmd & PWDATA[31];
    assign seq_start = wr_en & sel_cmd & ~PWDATA[31] & (|PWDATA[NB_CLUSTERS-1:0]);

    cluster_boot_seq #(
        .NB_CLUSTERS (NB_CLUSTERS),
        .DLY_WIDTH   (DLY_WIDTH)
    ) u_seq (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start_i    (seq_start),
        .clear_i    (seq_clear),
        .mask_i     (PWDATA[NB_CLUSTERS-1:0]),
        .dly_i      (boot_dly_q),
        .fetch_en_o (cluster_fetch_en_o),
        .busy_o     (busy),
        .idx_o      (idx)
    );

    // Per-core resource registers
    for (genvar k = 0; k < NB_RES; k++) begin : g_core
        logic [RES_WIDTH-1:0] res_q, res_d;

        assign res_sel[k] = (addr_w == (REG_RES_BASE + 8'(k)));

        // Capture the low RES_WIDTH bits of a write to this core's slot
        always_comb begin
            res_d = res_q;
            if (wr_en && res_sel[k]) begin
                res_d = PWDATA[RES_WIDTH-1:0];
            end
        end

        // Resource register storage
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign res_flat[k*RES_WIDTH +: RES_WIDTH] = res_q;
    end

    // Boot delay and boot address write updates
    always_comb begin
        boot_dly_d  = boot_dly_q;
        boot_addr_d = boot_addr_q;
        if (wr_en && sel_dly) begin
            boot_dly_d = PWDATA[DLY_WIDTH-1:0];
        end
        if (wr_en && sel_addr) begin
            boot_addr_d = PWDATA;
        end
    end

    // Boot delay and boot address storage
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            boot_dly_q  <= '0;
            boot_addr_q <= BOOT_ADDR_RST;
        end else begin
            boot_dly_q  <= boot_dly_d;
            boot_addr_q <= boot_addr_d;
        end
    end

    // Read mux; BOOT_CMD and unmapped addresses read as zero
    always_comb begin
        rdata = '0;
        if (sel_info) begin
            rdata = {16'(NB_CORES), 16'(NB_CLUSTERS)};
        end else if (sel_dly) begin
            rdata = 32'(boot_dly_q);
        end else if (sel_addr) begin
            rdata = boot_addr_q;
        end else if (sel_status) begin
            rdata[31]                = busy;
            rdata[26:24]             = idx;
            rdata[NB_CLUSTERS-1:0]   = cluster_fetch_en_o;
        end else begin
            for (int k = 0; k < NB_RES; k++) begin
                if (res_sel[k]) begin
                    rdata = 32'(res_flat[k*RES_WIDTH +: RES_WIDTH]);
                end
            end
        end
    end

    assign PRDATA      = PSEL ? rdata : 32'd0;
    assign PSLVERR     = access & err;
    assign PREADY      = 1'b1;
    assign boot_addr_o = boot_addr_q;
    assign res_core_o  = res_flat;

endmodule
